// File: rtl/lcd_rtc_display.sv
// HH:MM:SS clock with validated time-load and 12/24-hour mode, continuously
// refreshing a 2x16 HD44780 character LCD over an 8-bit bus with a generated E strobe.
module lcd_rtc_display #(
    parameter int TICK_DIV  = 1000,
    parameter int PWR_CYC   = 70,
    parameter int SLOT_CYC  = 4,
    parameter int E_HIGH    = 2,
    parameter int CLR_SLOTS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_mode12,
    input  logic       i_set_stb,
    input  logic [4:0] i_set_hour,
    input  logic [5:0] i_set_min,
    input  logic [5:0] i_set_sec,
    output logic       o_set_err,
    output logic       o_sec_tick,
    output logic       o_init_done,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW  = (PWR_CYC > 1) ? $clog2(PWR_CYC) : 1;
    localparam int SW  = $clog2(SLOT_CYC);
    localparam int IW  = $clog2(((CLR_SLOTS > 16) ? CLR_SLOTS : 16) + 1);

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PWR_MAX  = CW'(PWR_CYC - 1);
    localparam logic [SW-1:0] CYC_MAX  = SW'(SLOT_CYC - 1);
    localparam logic [SW-1:0] E_HI     = SW'(E_HIGH);
    localparam logic [IW-1:0] CLR_LAST = IW'(CLR_SLOTS);
    localparam logic [IW-1:0] COL_LAST = IW'(16);

    typedef enum logic [2:0] {PWRUP, FUNC, DISP, ENTRY, CLEAR, LINE1, LINE2} state_t;

    // ---------------- time of day ----------------
    logic [PW-1:0] r_presc;
    logic [4:0]    r_hour;
    logic [5:0]    r_min, r_sec;
    logic          r_sec_tick, r_set_err;
    logic          w_set_ok;

    assign w_set_ok = (i_set_hour <= 5'd23) && (i_set_min <= 6'd59) && (i_set_sec <= 6'd59);

    // A valid load wins over a coincident tick; the tick is simply lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc    <= '0;
            r_hour     <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_sec_tick <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_set_err  <= 1'b0;
            if (i_set_stb && w_set_ok) begin
                r_hour  <= i_set_hour;
                r_min   <= i_set_min;
                r_sec   <= i_set_sec;
                r_presc <= '0;
            end else begin
                if (i_set_stb) r_set_err <= 1'b1;
                if (i_run) begin
                    if (r_presc == PRE_MAX) begin
                        r_presc    <= '0;
                        r_sec_tick <= 1'b1;
                        if (r_sec == 6'd59) begin
                            r_sec <= '0;
                            if (r_min == 6'd59) begin
                                r_min  <= '0;
                                r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                            end else begin
                                r_min <= r_min + 6'd1;
                            end
                        end else begin
                            r_sec <= r_sec + 6'd1;
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
            end
        end
    end

    // ---------------- LCD sequencer ----------------
    state_t        r_state, n_state;
    logic [IW-1:0] r_idx, n_idx;
    logic [SW-1:0] r_cyc, n_cyc;
    logic [CW-1:0] r_pwr, n_pwr;
    logic          w_new_slot;

    always_comb begin
        n_state    = r_state;
        n_idx      = r_idx;
        n_cyc      = r_cyc;
        n_pwr      = r_pwr;
        w_new_slot = 1'b0;
        if (r_state == PWRUP) begin
            if (r_pwr == PWR_MAX) begin
                n_state    = FUNC;
                n_idx      = '0;
                n_cyc      = '0;
                w_new_slot = 1'b1;
            end else begin
                n_pwr = r_pwr + CW'(1);
            end
        end else if (r_cyc == CYC_MAX) begin
            w_new_slot = 1'b1;
            n_cyc      = '0;
            n_idx      = r_idx + IW'(1);
            case (r_state)
                FUNC:  n_state = DISP;
                DISP:  n_state = ENTRY;
                ENTRY: begin n_state = CLEAR; n_idx = '0; end
                CLEAR: if (r_idx == CLR_LAST) begin n_state = LINE1; n_idx = '0; end
                LINE1: if (r_idx == COL_LAST) begin n_state = LINE2; n_idx = '0; end
                LINE2: if (r_idx == COL_LAST) begin n_state = LINE1; n_idx = '0; end
                default: begin n_state = PWRUP; n_idx = '0; end
            endcase
        end else begin
            n_cyc = r_cyc + SW'(1);
        end
    end

    // ---------------- character generation from the frame snapshot ----------------
    logic [4:0] r_snap_h;
    logic [5:0] r_snap_m, r_snap_s;
    logic       r_snap_m12;
    logic [4:0] w_h12, w_hd;
    logic       w_pm;
    logic [15:0] w_hh, w_mm, w_ss;
    logic [3:0] w_col;
    logic [7:0] w_l1, w_l2;

    function automatic logic [15:0] f_ascii2(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] u;
        if      (v >= 6'd50) t = 6'd5;
        else if (v >= 6'd40) t = 6'd4;
        else if (v >= 6'd30) t = 6'd3;
        else if (v >= 6'd20) t = 6'd2;
        else if (v >= 6'd10) t = 6'd1;
        else                 t = 6'd0;
        u = v - (t << 3) - (t << 1);
        return {8'h30 + {2'b00, t}, 8'h30 + {2'b00, u}};
    endfunction

    assign w_h12 = (r_snap_h == 5'd0) ? 5'd12 : (r_snap_h > 5'd12) ? r_snap_h - 5'd12 : r_snap_h;
    assign w_hd  = r_snap_m12 ? w_h12 : r_snap_h;
    assign w_pm  = (r_snap_h >= 5'd12);
    assign w_hh  = f_ascii2({1'b0, w_hd});
    assign w_mm  = f_ascii2(r_snap_m);
    assign w_ss  = f_ascii2(r_snap_s);
    assign w_col = 4'(n_idx - IW'(1));

    always_comb begin
        w_l1 = " ";
        case (w_col)
            4'd4:  w_l1 = w_hh[15:8];
            4'd5:  w_l1 = w_hh[7:0];
            4'd6:  w_l1 = ":";
            4'd7:  w_l1 = w_mm[15:8];
            4'd8:  w_l1 = w_mm[7:0];
            4'd9:  w_l1 = ":";
            4'd10: w_l1 = w_ss[15:8];
            4'd11: w_l1 = w_ss[7:0];
            4'd13: w_l1 = r_snap_m12 ? (w_pm ? "P" : "A") : " ";
            4'd14: w_l1 = r_snap_m12 ? "M" : " ";
            default: w_l1 = " ";
        endcase
    end

    always_comb begin
        w_l2 = " ";
        case (w_col)
            4'd0: w_l2 = "M";
            4'd1: w_l2 = "O";
            4'd2: w_l2 = "D";
            4'd3: w_l2 = "E";
            4'd5: w_l2 = r_snap_m12 ? "1" : "2";
            4'd6: w_l2 = r_snap_m12 ? "2" : "4";
            4'd7: w_l2 = "H";
            default: w_l2 = " ";
        endcase
    end

    // Bus content of the slot being entered; clear's execution slots leave E low.
    logic       w_act, w_rs;
    logic [7:0] w_dat;

    always_comb begin
        w_act = 1'b0;
        w_rs  = 1'b0;
        w_dat = 8'h00;
        case (n_state)
            FUNC:  begin w_act = 1'b1; w_dat = 8'h38; end
            DISP:  begin w_act = 1'b1; w_dat = 8'h0C; end
            ENTRY: begin w_act = 1'b1; w_dat = 8'h06; end
            CLEAR: begin w_act = (n_idx == '0); w_dat = 8'h01; end
            LINE1: begin
                w_act = 1'b1;
                w_rs  = (n_idx != '0);
                w_dat = (n_idx == '0) ? 8'h80 : w_l1;
            end
            LINE2: begin
                w_act = 1'b1;
                w_rs  = (n_idx != '0);
                w_dat = (n_idx == '0) ? 8'hC0 : w_l2;
            end
            default: ;
        endcase
    end

    logic       r_e, r_rs, r_init_done;
    logic [7:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= PWRUP;
            r_idx       <= '0;
            r_cyc       <= '0;
            r_pwr       <= '0;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_init_done <= 1'b0;
            r_snap_h    <= '0;
            r_snap_m    <= '0;
            r_snap_s    <= '0;
            r_snap_m12  <= 1'b0;
        end else begin
            r_state <= n_state;
            r_idx   <= n_idx;
            r_cyc   <= n_cyc;
            r_pwr   <= n_pwr;
            r_e     <= w_act && (n_state != PWRUP) && (n_cyc != '0) && (n_cyc <= E_HI);
            if (w_new_slot && w_act) begin
                r_rs   <= w_rs;
                r_data <= w_dat;
            end
            if (w_new_slot && n_state == LINE1 && n_idx == '0) begin
                r_snap_h    <= r_hour;
                r_snap_m    <= r_min;
                r_snap_s    <= r_sec;
                r_snap_m12  <= i_mode12;
                r_init_done <= 1'b1;
            end
        end
    end

    assign o_set_err   = r_set_err;
    assign o_sec_tick  = r_sec_tick;
    assign o_init_done = r_init_done;
    assign o_lcd_e     = r_e;
    assign o_lcd_rs    = r_rs;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = r_data;

endmodule

// File: tb/tb_lcd_rtc_display.sv
// Scoreboard bench for lcd_rtc_display: LCD transfers and whole frames are
// checked by a monitor against queued expectations from the stimulus.
module tb_lcd_rtc_display;
    localparam int PWR_CYC = 70;

    logic       clk, rst, run, mode12, set_stb;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic       o_set_err, o_sec_tick, o_init_done, o_lcd_e, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    lcd_rtc_display #(.TICK_DIV(4), .PWR_CYC(PWR_CYC), .SLOT_CYC(4), .E_HIGH(2), .CLR_SLOTS(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_mode12(mode12),
        .i_set_stb(set_stb), .i_set_hour(set_hour), .i_set_min(set_min), .i_set_sec(set_sec),
        .o_set_err(o_set_err), .o_sec_tick(o_sec_tick), .o_init_done(o_init_done),
        .o_lcd_e(o_lcd_e), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
    );

    typedef struct { logic [8:0] rsd; logic init; bit chk_cyc; int ecyc; } xfer_t;
    typedef struct { logic [127:0] l1; logic [127:0] l2; } frame_t;

    xfer_t  xq[$];
    frame_t fq[$];
    int n_chk = 0, n_err = 0;
    int cyc = 0, n_ticks = 0, first_tick_cyc = -1, last_tick_cyc = -1;
    int n_line2 = 0, frames_done = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end

    initial begin
        forever begin
            @(posedge clk);
            if (rst) cyc = 0; else cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chks(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit           e_prev, claimed, rs_bad;
    int           pos;
    frame_t       cur;
    logic [127:0] g1, g2;

    task automatic lcd_xfer();
        xfer_t x;
        if (xq.size() > 0) begin
            x = xq.pop_front();
            chk("xfer_rs_data", {o_lcd_rs, o_lcd_data}, x.rsd);
            chk("xfer_rw", o_lcd_rw, 0);
            chk("xfer_init_done", o_init_done, x.init);
            if (x.chk_cyc) chk("first_e_cycle", cyc, x.ecyc);
        end
        if (!o_lcd_rs && o_lcd_data == 8'hC0) n_line2++;
        if (!o_lcd_rs && o_lcd_data == 8'h80) begin
            if (fq.size() > 0) begin
                cur = fq.pop_front();
                claimed = 1; pos = 0; rs_bad = 0; g1 = '0; g2 = '0;
            end
        end else if (claimed) begin
            if (pos < 16) begin
                g1 = {g1[119:0], o_lcd_data};
                if (!o_lcd_rs) rs_bad = 1;
            end else if (pos == 16) begin
                if (o_lcd_rs || o_lcd_data != 8'hC0) rs_bad = 1;
            end else begin
                g2 = {g2[119:0], o_lcd_data};
                if (!o_lcd_rs) rs_bad = 1;
            end
            pos++;
            if (pos == 33) begin
                chks("line1", g1, cur.l1);
                chks("line2", g2, cur.l2);
                chk("frame_rs_addr", rs_bad, 0);
                claimed = 0;
                frames_done++;
            end
        end
    endtask

    initial begin
        e_prev = 0; claimed = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                claimed = 0; e_prev = 0;
            end else begin
                if (o_sec_tick) begin
                    if (n_ticks == 0) first_tick_cyc = cyc;
                    n_ticks++;
                    last_tick_cyc = cyc;
                end
                if (o_lcd_e && !e_prev) lcd_xfer();
                e_prev = o_lcd_e;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nedge(); @(negedge clk); #1; endtask

    task automatic push_init();
        xq.push_back('{9'h038, 1'b0, 1'b1, PWR_CYC + 1});
        xq.push_back('{9'h00C, 1'b0, 1'b0, 0});
        xq.push_back('{9'h006, 1'b0, 1'b0, 0});
        xq.push_back('{9'h001, 1'b0, 1'b0, 0});
        xq.push_back('{9'h080, 1'b1, 1'b0, 0});
    endtask

    task automatic wait_init();
        for (int k = 0; k < 400 && xq.size() > 0; k++) nedge();
        chk("init_seq_drained", xq.size(), 0);
    endtask

    task automatic wait_frame(input int target);
        for (int k = 0; k < 600 && frames_done < target; k++) nedge();
        chk("frame_arrived", frames_done >= target, 1);
    endtask

    task automatic expect_frame(input logic [127:0] l1, input logic [127:0] l2);
        int t;
        nedge(); nedge();
        t = frames_done + 1;
        fq.push_back('{l1, l2});
        wait_frame(t);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                            output logic err);
        set_stb = 1; set_hour = h; set_min = m; set_sec = s;
        nedge();
        err = o_set_err;
        set_stb = 0;
    endtask

    task automatic wait_line2();
        int old;
        old = n_line2;
        for (int k = 0; k < 400 && n_line2 == old; k++) nedge();
        chk("line2_seen", n_line2 != old, 1);
    endtask

    // ---------------- directed stimulus ----------------
    logic err;
    int   t0, c0;

    initial begin
        rst = 1; run = 1; mode12 = 0; set_stb = 0; set_hour = 0; set_min = 0; set_sec = 0;
        repeat (2) nedge();
        chk("reset_outputs", {o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data, o_init_done, o_set_err, o_sec_tick}, 0);
        push_init();
        rst = 0;

        // Free-running from reset: 3600 ticks of 4 cycles each is one hour.
        repeat (14400) nedge();
        run = 0;
        chk("ticks_3600", n_ticks, 3600);
        chk("first_tick_cycle", first_tick_cyc, 4);
        chk("init_seq_drained", xq.size(), 0);
        expect_frame("    01:00:00    ", "MODE 24H        ");

        // Full rollover 23:59:59 -> 00:00:00.
        set_time(5'd23, 6'd59, 6'd59, err);
        chk("set_ok_no_err", err, 0);
        t0 = n_ticks; c0 = cyc; run = 1;
        repeat (4) nedge();
        run = 0;
        chk("rollover_tick", n_ticks, t0 + 1);
        chk("rollover_tick_cycle", last_tick_cyc, c0 + 4);
        expect_frame("    00:00:00    ", "MODE 24H        ");

        // Out-of-range loads are rejected with a one-cycle error.
        set_time(5'd24, 6'd0, 6'd0, err);
        chk("set_err_hour24", err, 1);
        nedge();
        chk("set_err_one_cycle", o_set_err, 0);
        set_time(5'd1, 6'd60, 6'd0, err);
        chk("set_err_min60", err, 1);
        expect_frame("    00:00:00    ", "MODE 24H        ");

        // Load coincident with a prescaler wrap: load wins, no tick.
        run = 1;
        repeat (3) nedge();
        t0 = n_ticks;
        set_time(5'd10, 6'd20, 6'd30, err);
        chk("coincident_no_tick", o_sec_tick, 0);
        run = 0;
        chk("coincident_tick_count", n_ticks, t0);
        expect_frame("    10:20:30    ", "MODE 24H        ");

        // 12-hour rendering.
        mode12 = 1;
        set_time(5'd0, 6'd5, 6'd0, err);
        expect_frame("    12:05:00 AM ", "MODE 12H        ");
        set_time(5'd12, 6'd0, 6'd0, err);
        expect_frame("    12:00:00 PM ", "MODE 12H        ");
        set_time(5'd13, 6'd45, 6'd9, err);
        expect_frame("    01:45:09 PM ", "MODE 12H        ");

        // Prescaler parked at 2 across a long stop: resumes two cycles from a tick.
        run = 1;
        nedge(); nedge();
        run = 0;
        t0 = n_ticks;
        repeat (5000) nedge();
        chk("stopped_no_ticks", n_ticks, t0);
        c0 = cyc; run = 1;
        nedge(); nedge();
        run = 0;
        chk("resume_tick_cycle", last_tick_cyc, c0 + 2);
        chk("resume_tick_count", n_ticks, t0 + 1);
        expect_frame("    01:45:10 PM ", "MODE 12H        ");

        // Running time during a frame: the snapshot at LINE1 slot 0 sees 16 ticks.
        wait_line2();
        set_stb = 1; set_hour = 0; set_min = 0; set_sec = 0; run = 1;
        nedge();
        set_stb = 0;
        t0 = frames_done + 1;
        fq.push_back('{"    12:00:16 AM ", "MODE 12H        "});
        wait_frame(t0);
        run = 0;

        // Asynchronous reset in the middle of LINE2, then full re-init.
        wait_line2();
        #7 rst = 1;
        #1 chk("async_reset_outputs", {o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data, o_init_done, o_set_err, o_sec_tick}, 0);
        push_init();
        nedge(); nedge();
        rst = 0;
        wait_init();
        expect_frame("    12:00:00 AM ", "MODE 12H        ");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_rtc_display.md
Name: lcd_rtc_display

Overview:
- Parametrised successor to the single-line LCD clock block.
- Keeps an HH:MM:SS time-of-day counter with a configurable tick divider, run/stop control, a validated time-load interface and a 12/24-hour display mode.
- Drives an HD44780-style 8-bit character LCD with a generated E strobe (not the raw clock) and refreshes both 16-column lines continuously, without a per-frame clear.
- Sits between the board clock/keypad logic and the LCD header.

Parameters:
TICK_DIV, 1000, CLK cycles per second tick (>=2)
PWR_CYC, 70, CLK cycles of power-up wait before first command
SLOT_CYC, 4, CLK cycles per LCD transfer slot (>=3)
E_HIGH, 2, cycles LCD_E is high within a slot, occupying slot cycles 1..E_HIGH (1 <= E_HIGH <= SLOT_CYC-2)
CLR_SLOTS, 8, slots held after the clear command (execution time)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
RUN  in  1  1 = time advances on ticks; 0 = time and prescaler hold
MODE12  in  1  1 = 12-hour display with AM/PM; 0 = 24-hour
SET_STB  in  1  one-cycle time-load request
SET_HOUR  in  5  load hour (0-23)
SET_MIN  in  6  load minute (0-59)
SET_SEC  in  6  load second (0-59)
SET_ERR  out  1  one-cycle pulse: SET_STB rejected (out of range)
SEC_TICK  out  1  one-cycle pulse when seconds advance
INIT_DONE  out  1  high once the init sequence has completed
LCD_E  out  1  LCD enable strobe
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  always 0 after reset (write only)
LCD_DATA  out  8  LCD data bus

Behaviour:
- Reset (async, any state): time 00:00:00, prescaler 0, state PWRUP. All outputs 0: LCD_E, LCD_RS, LCD_RW, LCD_DATA=0x00, INIT_DONE, SET_ERR, SEC_TICK.
- Prescaler counts 0..TICK_DIV-1 while RUN=1; it holds while RUN=0.
- When the prescaler wraps: SEC_TICK=1 for one cycle and seconds increment, with carries sec 59->0 => min+1; min 59->0 => hour+1; hour 23->0. Time registers update on the same edge as SEC_TICK.
- SET_STB with all fields in range: load the time and clear the prescaler on the next edge; no SEC_TICK that cycle. SET has priority over a coincident tick (the tick is dropped).
- SET_STB with any field out of range: time unchanged, SET_ERR=1 for one cycle.
- SET_STB is accepted regardless of RUN.
- FSM states: PWRUP, FUNC, DISP, ENTRY, CLEAR, LINE1, LINE2.
  - PWRUP: wait PWR_CYC cycles; no E pulses.
  - FUNC, DISP, ENTRY: each is one slot, RS=0, carrying 0x38, 0x0C, 0x06 respectively.
  - CLEAR: 0x01 in one slot, then CLR_SLOTS idle slots with E low.
  - INIT_DONE goes to 1 on entry to LINE1 and stays 1 until reset.
- LINE1 and LINE2 are 17 slots each: slot 0 is the address command (RS=0; 0x80 for LINE1, 0xC0 for LINE2), slots 1-16 are characters (RS=1). LINE2 -> LINE1 repeats forever; there is no further clear.
- Slot timing: RS and DATA are updated at slot cycle 0 and stay stable for the whole slot. E=1 only on cycles 1..E_HIGH. Setup and hold are therefore >= 1 cycle each.
- At LINE1 slot 0, the hour, min, sec and MODE12 values are snapshotted. Both lines render from this snapshot, so a frame never shows a torn time.
- LINE1 characters by column:
  - 0-3: spaces
  - 4-11: H1 H0 ':' M1 M0 ':' S1 S0 as ASCII digits (0x30+d)
  - 12: space
  - 13-14: "AM"/"PM" if MODE12, else spaces
  - 15: space
- 12-hour mapping: hour 0 -> 12 AM; 1-11 -> same value, AM; 12 -> 12 PM; 13-23 -> hour-12, PM. The leading zero is shown.
- LINE2: "MODE 24H" or "MODE 12H" in columns 0-7; columns 8-15 are spaces.
- Digit splitting (tens/units) is combinational on 0-59 values; no division IP.

Test Plan:
- Defaults, reset released -> first E high at cycle PWR_CYC+1. Sequence: 0x38, 0x0C, 0x06, 0x01 (RS=0), then 0x80. INIT_DONE=1 at LINE1 entry. RW=0 throughout.
- TICK_DIV=4, run from reset -> SEC_TICK every 4 cycles. After 3600 ticks time = 01:00:00. SET 23:59:59 followed by one tick -> 00:00:00.
- SET_STB with hour=24, or min=60 -> SET_ERR pulses, time unchanged. SET_STB coincident with a tick -> loaded value is held and no SEC_TICK fires.
- MODE12=1 with times 00:05:00, 12:00:00, 13:45:09 -> LINE1 decodes "12:05:00 AM", "12:00:00 PM", "01:45:09 PM". LINE2 decodes "MODE 12H".
- RUN=0 for 5000 cycles -> no SEC_TICK, time and prescaler frozen. Time advancing between LINE1 slot 0 and the end of LINE2 does not change the characters of the current frame.
- Assert RESET mid-LINE2 -> all outputs 0 immediately (asynchronously). After release, the full init sequence is replayed.
